eight_bit_comp_driver: RTL and testbench
========================================

EIGHT_BIT_COMP_DRIVER -- requirements
Module: eight_bit_comp_driver

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 2: cycles each PBx strobe is held high (legal range 1..15).
REQ-002 SHALL have parameter SETTLE_LEN, default 2: cycles waited after the last strobe before the result is sampled (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request to send one operand pair; sampled only in IDLE.
REQ-006 SHALL have ports a, b  input  8 each  operands; captured on the accepted start edge.
REQ-007 SHALL have ports PB1, PB2, PB3, PB4  output  1 each  load strobes: A low nibble, A high nibble, B low nibble, B high nibble.
REQ-008 SHALL have port Y  output  4  nibble bus to the comparator.
REQ-009 SHALL have ports l, g, eq  input  1 each  comparator result (less, greater, equal).
REQ-010 SHALL have ports res_l, res_g, res_eq  output  1 each  registered result of the last transaction.
REQ-011 SHALL have ports busy, done, err  output  1 each  transaction active; one-cycle completion pulse; result not one-hot.

Function
REQ-012 SHALL implement FSM states IDLE, SEND_A_LO, SEND_A_HI, SEND_B_LO, SEND_B_HI, SETTLE, CAPTURE.
REQ-013 In IDLE, start=1 at an edge SHALL latch a and b, set busy, and go to SEND_A_LO.
REQ-014 Each SEND state SHALL last PULSE_LEN+1 cycles: its PBx is high for the first PULSE_LEN cycles and low for the last cycle, with Y held at the nibble for all PULSE_LEN+1 cycles.
REQ-015 Nibble order SHALL be a[3:0], a[7:4], b[3:0], b[7:4] on PB1, PB2, PB3, PB4 respectively.
REQ-016 At most one PBx SHALL be high in any cycle; strobes never overlap or abut.
REQ-017 SETTLE SHALL last SETTLE_LEN cycles with all PBx low and Y holding b[7:4].
REQ-018 On the edge leaving SETTLE, l/g/eq SHALL be registered into res_l/res_g/res_eq, and err SHALL be set to 1 if {l,g,eq} is not exactly one-hot, else 0.
REQ-019 In CAPTURE, done SHALL be high for exactly one cycle; the next state is IDLE.
REQ-020 busy SHALL be high from the cycle after the accepted start through CAPTURE inclusive.
REQ-021 Latency SHALL be fixed: done is high 4*(PULSE_LEN+1)+SETTLE_LEN+1 cycles after the start edge (15 at defaults).
REQ-022 start SHALL be ignored while busy; a and b changing mid-transaction SHALL not affect the Y sequence.
REQ-023 start held high continuously SHALL begin a new transaction on the IDLE cycle following done (back-to-back, one IDLE cycle between).
REQ-024 In IDLE, Y SHALL be 0, and res_l, res_g, res_eq and err SHALL hold their last values.

Reset
REQ-025 With rst_n=0 at an edge, the FSM SHALL go to IDLE, and PB1-PB4, Y, busy, done, res_l, res_g, res_eq and err SHALL be 0 from the next cycle.
REQ-026 Reset during any SEND or SETTLE state SHALL abort the transaction with no done pulse and no result update.

Structure
REQ-027 Package eight_bit_comp_pkg SHALL hold the FSM state enum, the nibble-index constants (A_LO, A_HI, B_LO, B_HI) and the PULSE_LEN and SETTLE_LEN defaults.
REQ-028 A single sub-module, phase_timer (4-bit loadable down-counter with an expire flag), SHALL time the SEND and SETTLE phases.

Verification
REQ-029 a=0xA5, b=0x3C, start -> PB1 with Y=5, PB2 with Y=A, PB3 with Y=C, PB4 with Y=3, each high for 2 cycles with a 1-cycle gap.
REQ-030 a=0x3C, b=0x3C, model returns eq -> res_eq=1, res_l=0, res_g=0, err=0; done 15 cycles after start.
REQ-031 a=0x10, b=0x0F -> res_g=1; then a=0x00, b=0xFF -> res_l=1; run back-to-back with start held high.
REQ-032 start pulsed and a changed to 0xFF while busy -> no restart, Y sequence unchanged, single done.
REQ-033 rst_n=0 during SEND_B_LO -> next cycle all PBx=0, Y=0, busy=0; no done pulse.
REQ-034 Model forces l=1, g=1 at sample -> err=1, done pulses; next good transaction clears err.

Source files
------------

// File: rtl/eight_bit_comp_pkg.sv
// Shared types and constants for the 8-bit comparator driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, nibble-index constants, timing defaults,
//           helpers that map a nibble index to its bus value and strobe bit.
package eight_bit_comp_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_A_LO = 3'd1,
    SEND_A_HI = 3'd2,
    SEND_B_LO = 3'd3,
    SEND_B_HI = 3'd4,
    SETTLE    = 3'd5,
    CAPTURE   = 3'd6
  } state_t;

  // Order in which nibbles go out on Y; also the bit position of the strobe.
  localparam logic [1:0] A_LO = 2'd0;
  localparam logic [1:0] A_HI = 2'd1;
  localparam logic [1:0] B_LO = 2'd2;
  localparam logic [1:0] B_HI = 2'd3;

  localparam int PULSE_LEN_DEF  = 2;
  localparam int SETTLE_LEN_DEF = 2;

  function automatic logic [3:0] nibble_of(input logic [1:0] idx,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    logic [3:0] nib;
    case (idx)
      A_LO:    nib = a[3:0];
      A_HI:    nib = a[7:4];
      B_LO:    nib = b[3:0];
      B_HI:    nib = b[7:4];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  // Strobe vector {PB4,PB3,PB2,PB1} for a nibble index.
  function automatic logic [3:0] strobe_of(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/eight_bit_comp_driver_if.sv
// Bundle between the comparator driver, its requester and the external comparator.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the driver is not busy.
// Signals: start/a/b (request), PB1..PB4/Y (nibble loading), l/g/eq (comparator
//          answer), res_l/res_g/res_eq/err (captured result), busy/done (status).
interface eight_bit_comp_driver_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       PB1;
  logic       PB2;
  logic       PB3;
  logic       PB4;
  logic [3:0] Y;
  logic       l;
  logic       g;
  logic       eq;
  logic       res_l;
  logic       res_g;
  logic       res_eq;
  logic       busy;
  logic       done;
  logic       err;

  // Driver side.
  modport master (
    input  start, a, b, l, g, eq,
    output PB1, PB2, PB3, PB4, Y, res_l, res_g, res_eq, busy, done, err
  );

  // Requester / comparator side.
  modport slave (
    output start, a, b, l, g, eq,
    input  PB1, PB2, PB3, PB4, Y, res_l, res_g, res_eq, busy, done, err
  );
endinterface

// File: rtl/phase_timer.sv
// 4-bit loadable down-counter timing each SEND and SETTLE phase.
// Latency: loaded value appears the cycle after i_load; counts down to 0 and holds.
// Backpressure: none.
// Ports: clk, rst_n (sync active-low), i_load/i_load_val (reload), o_cnt (current
//        count), o_expire (count is zero: last cycle of the current phase).
module phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic [3:0] o_cnt,
  output logic       o_expire
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_expire = (r_cnt == 4'd0);

endmodule

// File: rtl/eight_bit_comp_driver.sv
// Sends two 8-bit operands to a nibble-wide comparator and captures its answer.
// Latency: done 4*(PULSE_LEN+1)+SETTLE_LEN+1 cycles after the accepted start edge.
// Backpressure: start ignored while busy; held start restarts after one IDLE cycle.
// Ports: clk, rst_n (sync active-low), io_bus (master modport: start/a/b in,
//        PB1..PB4/Y out, l/g/eq in, res_*/err/busy/done out).
module eight_bit_comp_driver
  import eight_bit_comp_pkg::*;
#(
  parameter int PULSE_LEN  = PULSE_LEN_DEF,
  parameter int SETTLE_LEN = SETTLE_LEN_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  eight_bit_comp_driver_if.master        io_bus
);

  // A SEND phase counts PULSE_LEN..0 (PULSE_LEN+1 cycles); SETTLE counts
  // SETTLE_LEN-1..0 so it lasts exactly SETTLE_LEN cycles.
  localparam logic [3:0] LP_PULSE     = 4'(PULSE_LEN);
  localparam logic [3:0] LP_SETTLE_M1 = 4'(SETTLE_LEN - 1);

  state_t     r_state;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [3:0] r_pb;
  logic [3:0] r_y;
  logic       r_res_l;
  logic       r_res_g;
  logic       r_res_eq;
  logic       r_err;
  logic       r_busy;
  logic       r_done;

  logic [3:0] w_cnt;
  logic       w_expire;
  logic       w_in_send;
  logic       w_last_send;
  logic       w_load;
  logic [3:0] w_load_val;
  logic [1:0] w_idx;
  logic [1:0] w_next_idx;

  always_comb begin
    w_idx     = A_LO;
    w_in_send = 1'b1;
    case (r_state)
      SEND_A_LO: w_idx = A_LO;
      SEND_A_HI: w_idx = A_HI;
      SEND_B_LO: w_idx = B_LO;
      SEND_B_HI: w_idx = B_HI;
      default:   w_in_send = 1'b0;
    endcase
  end

  assign w_next_idx  = w_idx + 2'd1;
  assign w_last_send = (r_state == SEND_B_HI);

  // Reload on acceptance and at every SEND phase boundary; SETTLE needs its own length.
  assign w_load     = ((r_state == IDLE) && io_bus.start) || (w_in_send && w_expire);
  assign w_load_val = w_last_send ? LP_SETTLE_M1 : LP_PULSE;

  phase_timer u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_cnt      (w_cnt),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_pb     <= 4'h0;
      r_y      <= 4'h0;
      r_res_l  <= 1'b0;
      r_res_g  <= 1'b0;
      r_res_eq <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            r_a     <= io_bus.a;
            r_b     <= io_bus.b;
            r_busy  <= 1'b1;
            r_pb    <= strobe_of(A_LO);
            r_y     <= nibble_of(A_LO, io_bus.a, io_bus.b);
            r_state <= SEND_A_LO;
          end
        end

        SEND_A_LO, SEND_A_HI, SEND_B_LO, SEND_B_HI: begin
          if (w_expire) begin
            if (w_last_send) begin
              // Y keeps b[7:4] through SETTLE.
              r_pb    <= 4'h0;
              r_state <= SETTLE;
            end else begin
              r_pb    <= strobe_of(w_next_idx);
              r_y     <= nibble_of(w_next_idx, r_a, r_b);
              r_state <= state_t'(r_state + 3'd1);
            end
          end else if (w_cnt == 4'd1) begin
            // Drop the strobe for the final (count 0) cycle so strobes never abut.
            r_pb <= 4'h0;
          end
        end

        SETTLE: begin
          if (w_expire) begin
            r_res_l  <= io_bus.l;
            r_res_g  <= io_bus.g;
            r_res_eq <= io_bus.eq;
            r_err    <= !$onehot({io_bus.l, io_bus.g, io_bus.eq});
            r_done   <= 1'b1;
            r_state  <= CAPTURE;
          end
        end

        CAPTURE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_y     <= 4'h0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.PB1    = r_pb[0];
  assign io_bus.PB2    = r_pb[1];
  assign io_bus.PB3    = r_pb[2];
  assign io_bus.PB4    = r_pb[3];
  assign io_bus.Y      = r_y;
  assign io_bus.res_l  = r_res_l;
  assign io_bus.res_g  = r_res_g;
  assign io_bus.res_eq = r_res_eq;
  assign io_bus.err    = r_err;
  assign io_bus.busy   = r_busy;
  assign io_bus.done   = r_done;

endmodule

// File: tb/tb_eight_bit_comp_driver.sv
// Self-checking bench for eight_bit_comp_driver with a behavioural nibble comparator.
// Latency: expects done LAT cycles after each accepted start.
// Backpressure: exercises start while busy and start held across done.
module tb_eight_bit_comp_driver;

  localparam int P    = 2;
  localparam int S    = 2;
  localparam int LAT  = 4 * (P + 1) + S + 1;
  localparam int NREC = 40;

  typedef logic [3:0] res_t;  // {res_l, res_g, res_eq, err}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eight_bit_comp_driver_if bus();

  eight_bit_comp_driver #(.PULSE_LEN(P), .SETTLE_LEN(S)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  // Behavioural comparator: loads nibbles on the strobes, answers combinationally.
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;
  bit         force_bad = 1'b0;

  always @(posedge clk) begin
    if (bus.PB1) m_a[3:0] <= bus.Y;
    if (bus.PB2) m_a[7:4] <= bus.Y;
    if (bus.PB3) m_b[3:0] <= bus.Y;
    if (bus.PB4) m_b[7:4] <= bus.Y;
  end

  assign bus.l  = force_bad ? 1'b1 : (m_a < m_b);
  assign bus.g  = force_bad ? 1'b1 : (m_a > m_b);
  assign bus.eq = force_bad ? 1'b0 : (m_a == m_b);

  int errors = 0;
  int checks = 0;
  res_t sb_q[$];

  logic [3:0] rec_pb   [NREC];
  logic [3:0] rec_y    [NREC];
  logic       rec_busy [NREC];
  logic       rec_done [NREC];
  res_t       rec_res  [NREC];

  function automatic res_t model_res(input logic [7:0] a, input logic [7:0] b, input bit bad);
    if (bad) return 4'b1101;
    return {a < b, a > b, a == b, 1'b0};
  endfunction

  // Drives one transaction (optionally a back-to-back second one) and records ncyc cycles.
  task automatic record_txn(input logic [7:0] a0, input logic [7:0] b0,
                            input logic [7:0] a1, input logic [7:0] b1,
                            input bit b2b, input bit poke, input bit bad0, input int ncyc);
    @(negedge clk);
    bus.a = a0; bus.b = b0; bus.start = 1'b1; force_bad = bad0;
    sb_q.push_back(model_res(a0, b0, bad0));
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      rec_pb[k]   = {bus.PB4, bus.PB3, bus.PB2, bus.PB1};
      rec_y[k]    = bus.Y;
      rec_busy[k] = bus.busy;
      rec_done[k] = bus.done;
      rec_res[k]  = {bus.res_l, bus.res_g, bus.res_eq, bus.err};
      if (!b2b && k == 1) bus.start = 1'b0;
      if (poke && k == 5) begin bus.start = 1'b1; bus.a = 8'hFF; end
      if (poke && k == 6) bus.start = 1'b0;
      if (b2b && k == LAT + 1) begin
        bus.a = a1; bus.b = b1; force_bad = 1'b0;
        sb_q.push_back(model_res(a1, b1, 1'b0));
      end
      if (b2b && k == LAT + 2) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    force_bad = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {bus.PB4, bus.PB3, bus.PB2, bus.PB1, bus.Y, bus.busy, bus.done, bus.res_l, bus.res_g};
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL reset_outputs: got %h want 000", obs); end
    checks++;
    if ({bus.res_eq, bus.err} !== 2'b00) begin
      errors++; $display("FAIL reset_res_eq_err: got %b want 00", {bus.res_eq, bus.err});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.Y} !== 5'h00) begin
      errors++; $display("FAIL idle_after_reset: got %h want 00", {bus.busy, bus.Y});
    end
  endtask

  task automatic test_sequence();
    logic [7:0]  ta = 8'hA5;
    logic [7:0]  tb = 8'h3C;
    logic [15:0] nibs;
    logic [9:0]  got, exp;
    int phase, pos;
    nibs = {tb[7:4], tb[3:0], ta[7:4], ta[3:0]};
    record_txn(ta, tb, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, LAT + 2);
    for (int k = 1; k <= LAT + 1; k++) begin
      phase = (k - 1) / (P + 1);
      pos   = (k - 1) % (P + 1);
      exp[9:6] = (k <= 4 * (P + 1) && pos < P) ? (4'b0001 << phase) : 4'b0000;
      exp[5:2] = (k <= 4 * (P + 1)) ? nibs[phase*4 +: 4] : ((k <= LAT) ? tb[7:4] : 4'h0);
      exp[1]   = (k <= LAT);
      exp[0]   = (k == LAT);
      got = {rec_pb[k], rec_y[k], rec_busy[k], rec_done[k]};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL seq_cycle%0d {pb,y,busy,done}: got %h want %h", k, got, exp);
      end
    end
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL seq_sb: got empty want 1 entry"); end
    else begin
      res_t e = sb_q.pop_front();
      if (rec_res[LAT] !== e) begin errors++; $display("FAIL seq_res: got %b want %b", rec_res[LAT], e); end
    end
  endtask

  task automatic test_equal();
    int first = -1;
    record_txn(8'h3C, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, LAT + 4);
    for (int k = 1; k <= LAT + 4; k++) if (rec_done[k] === 1'b1 && first < 0) first = k;
    checks++;
    if (first != LAT) begin errors++; $display("FAIL eq_latency: got %0d want %0d", first, LAT); end
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL eq_sb: got empty want 1 entry"); end
    else begin
      res_t e = sb_q.pop_front();
      if (rec_res[LAT] !== e) begin errors++; $display("FAIL eq_res: got %b want %b", rec_res[LAT], e); end
    end
    checks++;
    if (rec_res[LAT + 3] !== 4'b0010) begin
      errors++; $display("FAIL eq_hold_in_idle: got %b want 0010", rec_res[LAT + 3]);
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    record_txn(8'h10, 8'h0F, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 2 * LAT + 3);
    for (int k = 1; k <= 2 * LAT + 3; k++) begin
      if (rec_done[k] === 1'b1) begin
        ndone++;
        checks++;
        if (k != ndone * LAT + (ndone - 1)) begin
          errors++; $display("FAIL b2b_done%0d_cycle: got %0d want %0d", ndone, k, ndone * LAT + ndone - 1);
        end
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL b2b_sb: got empty want entry"); end
        else begin
          res_t e = sb_q.pop_front();
          if (rec_res[k] !== e) begin errors++; $display("FAIL b2b_res%0d: got %b want %b", ndone, rec_res[k], e); end
        end
      end
    end
    checks++;
    if (ndone != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
    checks++;
    if ({rec_busy[LAT + 1], rec_busy[LAT + 2]} !== 2'b01) begin
      errors++; $display("FAIL b2b_idle_gap busy: got %b want 01", {rec_busy[LAT + 1], rec_busy[LAT + 2]});
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] ta = 8'h5A;
    logic [7:0] tb = 8'hC3;
    logic [15:0] nibs;
    int ndone = 0;
    int bad = 0;
    int phase;
    nibs = {tb[7:4], tb[3:0], ta[7:4], ta[3:0]};
    record_txn(ta, tb, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2 * LAT + 2);
    for (int k = 1; k <= 2 * LAT + 2; k++) begin
      if (rec_done[k] === 1'b1) ndone++;
      phase = (k - 1) / (P + 1);
      if (k <= 4 * (P + 1) && rec_y[k] !== nibs[phase*4 +: 4]) bad++;
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL busy_single_done: got %0d want 1", ndone); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_y_sequence: got %0d bad cycles want 0", bad); end
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL busy_sb: got empty want 1 entry"); end
    else begin
      res_t e = sb_q.pop_front();
      if (rec_res[LAT] !== e) begin errors++; $display("FAIL busy_res: got %b want %b", rec_res[LAT], e); end
    end
  endtask

  task automatic test_reset_abort();
    logic [9:0] obs;
    int ndone = 0;
    @(negedge clk);
    bus.a = 8'h77; bus.b = 8'h11; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);          // now in cycle 7: first SEND_B_LO cycle
    checks++;
    if (bus.PB3 !== 1'b1) begin errors++; $display("FAIL abort_in_b_lo PB3: got %b want 1", bus.PB3); end
    rst_n = 1'b0;
    @(negedge clk);
    obs = {bus.PB4, bus.PB3, bus.PB2, bus.PB1, bus.Y, bus.busy, bus.done};
    checks++;
    if (obs !== 10'h000) begin errors++; $display("FAIL abort_outputs: got %h want 000", obs); end
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 5; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", ndone); end
  endtask

  task automatic test_err();
    record_txn(8'h42, 8'h24, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, LAT + 1);
    checks++;
    if (rec_done[LAT] !== 1'b1) begin errors++; $display("FAIL err_done: got %b want 1", rec_done[LAT]); end
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL err_sb: got empty want 1 entry"); end
    else begin
      res_t e = sb_q.pop_front();
      if (rec_res[LAT] !== e) begin errors++; $display("FAIL err_res: got %b want %b", rec_res[LAT], e); end
    end
    record_txn(8'h24, 8'h42, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, LAT + 1);
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL err_clear_sb: got empty want 1 entry"); end
    else begin
      res_t e = sb_q.pop_front();
      if (rec_res[LAT] !== e) begin errors++; $display("FAIL err_clear_res: got %b want %b", rec_res[LAT], e); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    test_reset();
    test_sequence();
    test_equal();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    test_err();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
